// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU and iterative multiply/divide unit.
// Latency: n/a (types and encodings only).
// Backpressure: n/a.
// Contents: ALU op encodings, multiply/divide op encodings, MDU FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_ANDN = 4'b0100,
    ALU_ORN  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_SRL  = 4'b1011,
    ALU_SRA  = 4'b1100,
    ALU_MFHI = 4'b1101,
    ALU_MFLO = 4'b1110,
    ALU_ZERO = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Latency: WIDTH+1 cycles from accepted start to done (WIDTH iterations + sign fix).
// Backpressure: start is only sampled in IDLE; starts while busy are dropped.
// Ports: start_i/op_i/a_i/b_i launch an op; busy_o while iterating;
//        done_o one-cycle pulse coincident with the HI/LO update; hi_o/lo_o results.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e          state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               accept;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign accept = (state_q == IDLE) && start_i;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (cnt_q == SHW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

  // Operand conditioning: unsigned ops never negate.
  always_comb begin
    signed_op = (md_op_e'(op_i) == MD_MULT) || (md_op_e'(op_i) == MD_DIV);
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
  end

  // One iteration step for each algorithm.
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set; the carry lands in bit WIDTH.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                (acc_q[0] ? {1'b0, b_mag_q} : '0);
    // Restoring divide: remainder shifted left with next dividend bit,
    // minus divisor. Bit WIDTH set means the subtraction went negative.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_mag_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_mag_d   = b_mag_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          b_mag_d   = b_mag;
          a_raw_d   = a_i;
          is_div_d  = op_i[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
        end
      end
      RUN: begin
        cnt_d = cnt_q + SHW'(1);
        if (is_div_q) begin
          if (!div_trial[WIDTH])
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (b_mag_q == '0) begin
          // Divide by zero: dividend passes through, quotient saturates.
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      b_mag_q   <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_mag_q   <= b_mag_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU (combinational op mux + zero/overflow flags) with an
// attached iterative multiply/divide unit.
// Latency: ALU 0 cycles; multiply/divide WIDTH+1 cycles. Backpressure: controller
// stalls on busy; md_start while busy is ignored.
// Ports: ALUcontrol/SrcA/SrcB -> ALUresult/zero/overflow; md_start/md_op launch
//        the MDU; busy/done handshake; hi/lo architectural registers.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUresult,
  output logic             zero,
  output logic             overflow,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] sum, diff;
  logic [SHW-1:0]   shamt;

  assign sum   = SrcA + SrcB;
  assign diff  = SrcA - SrcB;
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    ALUresult = '0;
    overflow  = 1'b0;
    unique case (alu_op_e'(ALUcontrol))
      ALU_AND:  ALUresult = SrcA & SrcB;
      ALU_OR:   ALUresult = SrcA | SrcB;
      ALU_ADD: begin
        ALUresult = sum;
        overflow  = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      ALU_XOR:  ALUresult = SrcA ^ SrcB;
      ALU_ANDN: ALUresult = SrcA & ~SrcB;
      ALU_ORN:  ALUresult = SrcA | ~SrcB;
      ALU_SUB: begin
        ALUresult = diff;
        // Signs of A and -B agree exactly when A and B signs differ.
        overflow  = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      ALU_SLT:  ALUresult = WIDTH'($signed(SrcA) < $signed(SrcB));
      ALU_NOR:  ALUresult = ~(SrcA | SrcB);
      ALU_SLTU: ALUresult = WIDTH'(SrcA < SrcB);
      ALU_SLL:  ALUresult = SrcA << shamt;
      ALU_SRL:  ALUresult = SrcA >> shamt;
      ALU_SRA:  ALUresult = $unsigned($signed(SrcA) >>> shamt);
      ALU_MFHI: ALUresult = hi;
      ALU_MFLO: ALUresult = lo;
      ALU_ZERO: ALUresult = '0;
      default:  ALUresult = '0;
    endcase
  end

  assign zero = (ALUresult == '0);

  mdu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .op_i    (md_op),
    .a_i     (SrcA),
    .b_i     (SrcB),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32): ALU sweep and flags,
// multiply/divide results and latency, ignored mid-run start, restart on done,
// and reset mid-run. MDU expectations go through a scoreboard queue.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALUcontrol;
  logic [31:0] SrcA, SrcB;
  logic [31:0] ALUresult;
  logic        zero, overflow;
  logic        md_start;
  logic [1:0]  md_op;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_sweep [16];

  alu_mdu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUcontrol (ALUcontrol),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUresult  (ALUresult),
    .zero       (zero),
    .overflow   (overflow),
    .md_start   (md_start),
    .md_op      (md_op),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic alu_chk(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic eo);
    @(negedge clk);
    ALUcontrol = c; SrcA = a; SrcB = b;
    #1;
    chk({tag, "/res"},  64'(ALUresult), 64'(er));
    chk({tag, "/zero"}, 64'(zero),      64'(er == 32'd0));
    chk({tag, "/ovf"},  64'(overflow),  64'(eo));
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv);
    md_op = op; SrcA = a; SrcB = b; md_start = 1'b1;
    sb.push_back(expv);
  endtask

  // Called just before the accepting edge; returns #1 after the done edge.
  task automatic wait_done(input string tag, input int glitch_at);
    int n;
    logic [63:0] e;
    @(posedge clk); #1;
    md_start = 1'b0;
    chk({tag, "/busy"}, 64'(busy), 64'(1));
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == glitch_at) begin
        md_start = 1'b1; md_op = 2'b11; SrcA = 32'd100; SrcB = 32'd3;
      end else begin
        md_start = 1'b0;
      end
    end
    chk({tag, "/lat"}, 64'(n), 64'(33));
    chk({tag, "/busy_end"}, 64'(busy), 64'(0));
    e = sb.pop_front();
    chk({tag, "/hilo"}, {hi, lo}, e);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
  endtask

  initial begin
    int nd;
    logic [63:0] keep;
    rst_n = 1'b0; ALUcontrol = 4'd0; SrcA = '0; SrcB = '0; md_start = 1'b0; md_op = 2'b00;
    exp_sweep = '{32'h0, 32'hF4, 32'hF4, 32'hF4, 32'hF0, 32'hFFFF_FFFB, 32'hEC, 32'h0,
                  32'hFFFF_FF0B, 32'h0, 32'hF00, 32'hF, 32'hF, 32'h0, 32'h0, 32'h0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/busy", 64'(busy), 64'(0));
    chk("rst/done", 64'(done), 64'(0));
    chk("rst/hi",   64'(hi),   64'(0));
    chk("rst/lo",   64'(lo),   64'(0));
    rst_n = 1'b1;

    // ALU sweep
    for (int i = 0; i < 16; i++)
      alu_chk($sformatf("sweep%0d", i), 4'(i), 32'h0000_00F0, 32'h0000_0004, exp_sweep[i], 1'b0);

    // Flags and signed corners
    alu_chk("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    alu_chk("sub_ovf",  4'b0110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1);
    alu_chk("sub_zero", 4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0);
    alu_chk("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    alu_chk("slt_neg",  4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
    alu_chk("sltu_big", 4'b1001, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    alu_chk("sra_neg",  4'b1100, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0);
    alu_chk("sll_amt",  4'b1010, 32'h1, 32'h0000_0103, 32'h8, 1'b0);

    // Multiply / divide
    @(negedge clk); launch(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("mult", -1);
    alu_chk("mfhi", 4'b1101, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    alu_chk("mflo", 4'b1110, 32'h0, 32'h0, 32'hFFFF_FFF1, 1'b0);
    @(negedge clk); launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done("multu", -1);
    @(negedge clk); launch(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("div_neg", -1);
    @(negedge clk); launch(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
    wait_done("div_negb", -1);
    @(negedge clk); launch(2'b11, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    wait_done("divu_z", -1);
    @(negedge clk); launch(2'b10, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
    wait_done("div_z", -1);
    @(negedge clk); launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    wait_done("div_mneg", -1);

    // Start pulsed mid-run is ignored; HI/LO change once.
    @(negedge clk); launch(2'b01, 32'd6, 32'd7, 64'h0000_0000_0000_002A);
    wait_done("ignore", 5);
    keep = {hi, lo};
    count_done(40, nd);
    chk("ignore/extra_done", 64'(nd), 64'(0));
    chk("ignore/hilo_hold", {hi, lo}, keep);

    // Restart on the done cycle
    @(negedge clk); launch(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    wait_done("divu", -1);
    chk("restart/done_high", 64'(done), 64'(1));
    launch(2'b00, 32'd3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4);
    wait_done("restart", -1);

    // Reset at run cycle 10
    @(negedge clk);
    md_op = 2'b01; SrcA = 32'd5; SrcB = 32'd5; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstrun/hi",   64'(hi),   64'(0));
    chk("rstrun/lo",   64'(lo),   64'(0));
    chk("rstrun/busy", 64'(busy), 64'(0));
    chk("rstrun/done", 64'(done), 64'(0));
    rst_n = 1'b1;
    count_done(40, nd);
    chk("rstrun/no_done", 64'(nd), 64'(0));
    chk("sb/empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
